// File: rtl/comp_sweep_pkg.sv
// Shared types, default sizing and the reference comparison used by the
// comparator self-test sweeper.
package comp_sweep_pkg;

    localparam int unsigned DEF_WIDTH  = 4;
    localparam int unsigned DEF_SETTLE = 1;
    localparam int unsigned SETTLE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    // Golden EQ for an operand pair; operands are zero-extended by the caller.
    function automatic logic expected_eq(input logic [31:0] a, input logic [31:0] b);
        return (a == b);
    endfunction

endpackage

// File: rtl/sweep_pair_counter.sv
// Concatenated {A,B} operand counter with synchronous clear/enable and a
// terminal-count flag for the last pair.
module sweep_pair_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic             o_tc_c
);

    localparam int unsigned CW = 2 * WIDTH;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // B is the low field so it sweeps as the inner loop.
    assign o_a    = r_cnt[CW-1:WIDTH];
    assign o_b    = r_cnt[WIDTH-1:0];
    assign o_tc_c = &r_cnt;

endmodule

// File: rtl/comp_pair_sweeper.sv
// Exhaustive operand-pair sweeper for an equality comparator: drives every
// (A,B), checks EQ after a settle window, counts errors and keeps the first.
module comp_pair_sweeper
    import comp_sweep_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned SETTLE = DEF_SETTLE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   A_out,
    output logic [WIDTH-1:0]   B_out,
    input  logic               EQ_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH:0]   err_cnt,
    output logic               err_valid,
    output logic [WIDTH-1:0]   first_err_a,
    output logic [WIDTH-1:0]   first_err_b
);

    localparam int unsigned ERR_W = 2 * WIDTH + 1;

    sweep_state_t        r_state, w_state_nxt;
    logic [SETTLE_W-1:0] r_settle, w_settle_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_err_valid, w_err_valid_nxt;
    logic [ERR_W-1:0]    r_err_cnt, w_err_cnt_nxt;
    logic [WIDTH-1:0]    r_first_a, w_first_a_nxt;
    logic [WIDTH-1:0]    r_first_b, w_first_b_nxt;

    logic [WIDTH-1:0]    w_a, w_b;
    logic                w_tc_c;
    logic                w_cnt_clr, w_cnt_en;
    logic                w_sample, w_mismatch;

    sweep_pair_counter #(
        .WIDTH (WIDTH)
    ) u_pair_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_a    (w_a),
        .o_b    (w_b),
        .o_tc_c (w_tc_c)
    );

    // The sample edge closes the last settle cycle of the current pair.
    assign w_sample   = (r_state == HOLD) && (r_settle == SETTLE_W'(SETTLE));
    assign w_mismatch = (EQ_in != expected_eq(32'(w_a), 32'(w_b)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_settle    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_cnt   <= '0;
            r_first_a   <= '0;
            r_first_b   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_settle    <= w_settle_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err_valid <= w_err_valid_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_first_a   <= w_first_a_nxt;
            r_first_b   <= w_first_b_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_settle_nxt    = r_settle;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_err_valid_nxt = r_err_valid;
        w_err_cnt_nxt   = r_err_cnt;
        w_first_a_nxt   = r_first_a;
        w_first_b_nxt   = r_first_b;
        w_cnt_clr       = 1'b0;
        w_cnt_en        = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt     = HOLD;
                    w_busy_nxt      = 1'b1;
                    w_done_nxt      = 1'b0;
                    w_cnt_clr       = 1'b1;
                    w_settle_nxt    = '0;
                    w_err_cnt_nxt   = '0;
                    w_err_valid_nxt = 1'b0;
                    w_first_a_nxt   = '0;
                    w_first_b_nxt   = '0;
                end
            end
            HOLD: begin
                if (w_sample) begin
                    w_settle_nxt = '0;
                    if (w_mismatch) begin
                        w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
                        if (!r_err_valid) begin
                            w_err_valid_nxt = 1'b1;
                            w_first_a_nxt   = w_a;
                            w_first_b_nxt   = w_b;
                        end
                    end
                    // Last pair: operands stay parked at max.
                    if (w_tc_c) begin
                        w_state_nxt = DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end else begin
                    w_settle_nxt = r_settle + SETTLE_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    assign A_out       = w_a;
    assign B_out       = w_b;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_cnt     = r_err_cnt;
    assign err_valid   = r_err_valid;
    assign first_err_a = r_first_a;
    assign first_err_b = r_first_b;

endmodule

// File: doc/comp_pair_sweeper.md
Name: comp_pair_sweeper

Overview:
- Operand-side counterpart of the equality comparator `comp_4bits`.
- Generates every (A, B) operand pair in hardware, drives them into a comparator, samples the comparator's EQ result and checks it against the expected value (A == B).
- Accumulates an error count and records the first failing pair.
- Used as an on-chip self-test harness around `comp_4bits` and its wider variants.

Parameters:
- WIDTH, 4, operand width in bits. Sweep covers 2^(2*WIDTH) pairs.
- SETTLE, 1, number of extra cycles each pair is held before EQ is sampled. Allowed range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begins a sweep when sampled high in IDLE or DONE.
- A_out  output  WIDTH  operand A driven to the comparator.
- B_out  output  WIDTH  operand B driven to the comparator.
- EQ_in  input  1  comparator result for the current A_out/B_out.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next start or reset.
- err_cnt  output  2*WIDTH+1  number of mismatching pairs.
- err_valid  output  1  high once at least one mismatch has been recorded.
- first_err_a  output  WIDTH  A value of the first mismatch.
- first_err_b  output  WIDTH  B value of the first mismatch.

Behaviour:
- Reset is synchronous and active-low:
  - State returns to IDLE.
  - A_out, B_out, err_cnt, first_err_a and first_err_b are all 0.
  - busy, done and err_valid are all 0.
  - A reset in mid-sweep aborts the sweep with the same values. No partial results are retained.
- States: IDLE, HOLD, DONE.
- IDLE/DONE -> HOLD on the edge where start=1:
  - busy=1, done=0, A_out=0, B_out=0.
  - err_cnt, err_valid, first_err_a and first_err_b are cleared on that same edge.
- HOLD, per-pair timing:
  - Each pair is held on A_out/B_out for exactly SETTLE+1 cycles. A settle counter counts 0..SETTLE.
  - EQ_in is sampled at the rising edge that ends the pair's final cycle.
  - expected = (A_out == B_out).
- HOLD, on mismatch (EQ_in != expected):
  - err_cnt increments.
  - If err_valid was 0: capture A_out into first_err_a and B_out into first_err_b, and set err_valid=1.
  - Later mismatches do not overwrite the captured pair.
- HOLD, pair ordering:
  - B is the inner loop and A the outer loop: (0,0), (0,1) … (0,max), (1,0) … (max,max).
  - Equivalently, {A_out, B_out} is a 2*WIDTH-bit counter incremented by 1.
- HOLD -> DONE on the sample edge of pair (max,max):
  - busy=0 and done=1 on the same edge.
  - A_out and B_out hold at max.
- Total busy time is 2^(2*WIDTH) * (SETTLE+1) cycles. With the defaults that is 512 cycles.
- start is ignored while in HOLD.
- start held continuously high restarts the sweep on the edge after DONE is entered.
- err_cnt has one more bit than the pair counter, so the worst case (all 2^(2*WIDTH) pairs fail) is representable. No saturation logic is required.
- EQ_in is treated as synchronous to clk. No synchroniser is used. Its value is relevant only on sample edges.
- SETTLE=0: the settle counter is degenerate, each pair lasts 1 cycle and EQ_in is sampled every edge.

Decomposition:
- Package comp_sweep_pkg contains:
  - state enum sweep_state_t {IDLE, HOLD, DONE}.
  - Default constants for WIDTH and SETTLE.
  - Function expected_eq(a, b).
- One sub-module, sweep_pair_counter:
  - 2*WIDTH-bit counter with synchronous clear and enable.
  - Outputs a terminal-count flag and the split A/B fields.
- The top level keeps the FSM, settle counter and error capture.

Test Plan:
1. Ideal comparator model, WIDTH=4, SETTLE=1, start pulsed 1 cycle.
   -> busy high for exactly 512 cycles, then done=1, err_cnt=0, err_valid=0, A_out=B_out=15.
2. EQ_in stuck at 0.
   -> err_cnt=16, err_valid=1, first_err_a=0, first_err_b=0.
3. EQ_in stuck at 1.
   -> err_cnt=240, first_err_a=0, first_err_b=1.
   Then inverted comparator -> err_cnt=256 (MSB set), first error (0,0).
4. rst_n low for 1 cycle while A_out=6, B_out=4, after 3 mismatches injected.
   -> next cycle state IDLE and all outputs 0.
   A subsequent start begins again from (0,0).
5. start pulsed while busy at pair (2,9); later start after DONE with a fault-free model.
   -> the mid-sweep start does not disturb the pair sequence.
   -> the restart clears err_cnt from the previous value to 0.
6. SETTLE=0 and SETTLE=3, with a model whose EQ lags operand changes by SETTLE cycles.
   -> err_cnt=0. Total busy cycles 256 and 1024 respectively.
